// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode map and control FSM states.
package cpu_pkg;

   localparam int CPU_AW = 8;
   localparam int CPU_DW = 8;

   localparam logic [7:0] OP_HALT = 8'h04;
   localparam logic [7:0] OP_JMP  = 8'h10;
   localparam logic [7:0] OP_LDSP = 8'h15;
   localparam logic [7:0] OP_PUSH = 8'h16;
   localparam logic [7:0] OP_POP  = 8'h17;
   localparam logic [7:0] OP_CALL = 8'h18;
   localparam logic [7:0] OP_RET  = 8'h19;

   typedef enum logic [3:0] {
      ST_RESET   = 4'd0,
      ST_FETCH_U = 4'd1,
      ST_FETCH_L = 4'd2,
      ST_DECODE  = 4'd3,
      ST_EXEC    = 4'd4,
      ST_SPDECR  = 4'd5,
      ST_SPM     = 4'd6,
      ST_SPR     = 4'd7,
      ST_SPLAC   = 4'd8,
      ST_HALT    = 4'd9
   } cpu_state_e;

endpackage

// File: rtl/addr_unit_if.sv
// Strobe and memory-port bundle between the control FSM / memory and addr_unit.
interface addr_unit_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] ac;

   logic LOAD_IRU, LOAD_IRL, LOAD_PC, INCR_PC, FETCH;
   logic LOAD_SP, DECR_SP, INCR_SP, FETCH_SP, FETCH_DATA, STORE_MEM;

   logic [DW-1:0] opcode;
   logic [AW-1:0] operand;
   logic [AW-1:0] pc;
   logic [AW-1:0] sp;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          stk_ovf;
   logic          stk_unf;
   logic [15:0]   instr_cnt;

   modport master (
      output mem_rdata, ac,
      output LOAD_IRU, LOAD_IRL, LOAD_PC, INCR_PC, FETCH,
      output LOAD_SP, DECR_SP, INCR_SP, FETCH_SP, FETCH_DATA, STORE_MEM,
      input  opcode, operand, pc, sp, mem_addr, mem_wdata, mem_we,
      input  stk_ovf, stk_unf, instr_cnt
   );

   modport slave (
      input  mem_rdata, ac,
      input  LOAD_IRU, LOAD_IRL, LOAD_PC, INCR_PC, FETCH,
      input  LOAD_SP, DECR_SP, INCR_SP, FETCH_SP, FETCH_DATA, STORE_MEM,
      output opcode, operand, pc, sp, mem_addr, mem_wdata, mem_we,
      output stk_ovf, stk_unf, instr_cnt
   );
endinterface

// File: rtl/stack_ptr.sv
// Stack pointer with full/empty guards and sticky fault flags.
// Stack grows downward from SP_INIT (empty) to SP_LIMIT (full).
module stack_ptr
   import cpu_pkg::*;
#(
   parameter int            AW       = CPU_AW,
   parameter logic [AW-1:0] SP_INIT  = 8'hFF,
   parameter logic [AW-1:0] SP_LIMIT = 8'hE0
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          load_sp,
   input  logic          decr_sp,
   input  logic          incr_sp,
   input  logic [AW-1:0] operand,
   output logic [AW-1:0] sp,
   output logic          stk_ovf,
   output logic          stk_unf
);

   logic [AW-1:0] sp_q, sp_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   // Next SP and flags: load > push > pop; a blocked move holds SP and latches its flag.
   always_comb begin
      sp_d  = sp_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (load_sp) begin
         sp_d  = operand;
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else if (decr_sp) begin
         if (sp_q == SP_LIMIT) ovf_d = 1'b1;
         else                  sp_d  = sp_q - AW'(1);
      end else if (incr_sp) begin
         if (sp_q == SP_INIT) unf_d = 1'b1;
         else                 sp_d  = sp_q + AW'(1);
      end
   end

   // State registers with synchronous reset taking precedence over all strobes.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sp_q  <= SP_INIT;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign sp      = sp_q;
   assign stk_ovf = ovf_q;
   assign stk_unf = unf_q;

endmodule

// File: rtl/addr_unit.sv
// Datapath registers (PC, split IR, SP) and memory address/data muxing.
module addr_unit
   import cpu_pkg::*;
#(
   parameter int            AW       = CPU_AW,
   parameter int            DW       = CPU_DW,
   parameter logic [AW-1:0] SP_INIT  = 8'hFF,
   parameter logic [AW-1:0] SP_LIMIT = 8'hE0
) (
   input logic        CLK,
   input logic        RESET,
   addr_unit_if.slave bus
);

   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] opcode_q, opcode_d;
   logic [AW-1:0] operand_q, operand_d;
   logic [15:0]   instr_cnt_q, instr_cnt_d;
   logic [AW-1:0] sp;
   logic          stk_ovf;
   logic          stk_unf;

   // Next-state for IR halves, PC (jump beats increment) and the fetch counter.
   always_comb begin
      opcode_d    = opcode_q;
      operand_d   = operand_q;
      pc_d        = pc_q;
      instr_cnt_d = instr_cnt_q;
      if (bus.LOAD_IRU) begin
         opcode_d    = bus.mem_rdata;
         instr_cnt_d = instr_cnt_q + 16'd1;
      end
      if (bus.LOAD_IRL) operand_d = bus.mem_rdata;
      if (bus.LOAD_PC)      pc_d = operand_q;
      else if (bus.INCR_PC) pc_d = pc_q + AW'(1);
   end

   // Register update; reset wins over any strobe on the same edge.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pc_q        <= '0;
         opcode_q    <= '0;
         operand_q   <= '0;
         instr_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         opcode_q    <= opcode_d;
         operand_q   <= operand_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   stack_ptr #(
      .AW       (AW),
      .SP_INIT  (SP_INIT),
      .SP_LIMIT (SP_LIMIT)
   ) u_stack_ptr (
      .CLK     (CLK),
      .RESET   (RESET),
      .load_sp (bus.LOAD_SP),
      .decr_sp (bus.DECR_SP),
      .incr_sp (bus.INCR_SP),
      .operand (operand_q),
      .sp      (sp),
      .stk_ovf (stk_ovf),
      .stk_unf (stk_unf)
   );

   // Memory port is purely combinational from current registers, so a same-cycle
   // LOAD_PC still addresses the old PC.
   always_comb begin
      if (bus.FETCH_SP)  bus.mem_addr = sp;
      else if (bus.FETCH) bus.mem_addr = pc_q;
      else               bus.mem_addr = operand_q;
   end

   assign bus.mem_wdata = bus.FETCH_DATA ? pc_q : bus.ac;
   assign bus.mem_we    = bus.STORE_MEM;

   assign bus.opcode    = opcode_q;
   assign bus.operand   = operand_q;
   assign bus.pc        = pc_q;
   assign bus.sp        = sp;
   assign bus.stk_ovf   = stk_ovf;
   assign bus.stk_unf   = stk_unf;
   assign bus.instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_addr_unit.sv
// Scoreboard bench for addr_unit: stimulus queues expectations, monitor checks them.
module tb_addr_unit;

   logic CLK;
   logic RESET;

   addr_unit_if #(.AW(8), .DW(8)) bus ();

   addr_unit dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   localparam logic [11:0] B_RST  = 12'h001;
   localparam logic [11:0] B_IRU  = 12'h002;
   localparam logic [11:0] B_IRL  = 12'h004;
   localparam logic [11:0] B_LPC  = 12'h008;
   localparam logic [11:0] B_IPC  = 12'h010;
   localparam logic [11:0] B_FET  = 12'h020;
   localparam logic [11:0] B_LSP  = 12'h040;
   localparam logic [11:0] B_DSP  = 12'h080;
   localparam logic [11:0] B_ISP  = 12'h100;
   localparam logic [11:0] B_FSP  = 12'h200;
   localparam logic [11:0] B_FDAT = 12'h400;
   localparam logic [11:0] B_STM  = 12'h800;

   localparam int S_OPC = 0, S_OPR = 1, S_PC = 2, S_SP = 3, S_ADDR = 4;
   localparam int S_WD = 5, S_WE = 6, S_OVF = 7, S_UNF = 8, S_CNT = 9;

   typedef struct {
      int          due;
      int          sel;
      logic [15:0] val;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   mcyc = 0;
   int   now_c = 0;
   int   total = 0;
   int   bad = 0;

   always @(posedge CLK) mcyc <= mcyc + 1;

   function automatic logic [15:0] getv(input int sel);
      case (sel)
         S_OPC:   return {8'h00, bus.opcode};
         S_OPR:   return {8'h00, bus.operand};
         S_PC:    return {8'h00, bus.pc};
         S_SP:    return {8'h00, bus.sp};
         S_ADDR:  return {8'h00, bus.mem_addr};
         S_WD:    return {8'h00, bus.mem_wdata};
         S_WE:    return {15'h0, bus.mem_we};
         S_OVF:   return {15'h0, bus.stk_ovf};
         S_UNF:   return {15'h0, bus.stk_unf};
         default: return bus.instr_cnt;
      endcase
   endfunction

   // Monitor: just before each rising edge, compare everything due this cycle.
   initial begin
      forever begin
         @(negedge CLK);
         #2;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due < mcyc) begin
               total++;
               bad++;
               $display("FAIL %s: check missed (due %0d, now %0d)", sb[i].nm, sb[i].due, mcyc);
               sb.delete(i);
            end else if (sb[i].due == mcyc) begin
               logic [15:0] got;
               got = getv(sb[i].sel);
               total++;
               if (got !== sb[i].val) begin
                  bad++;
                  $display("FAIL %s: got %h want %h", sb[i].nm, got, sb[i].val);
               end
               sb.delete(i);
            end
         end
      end
   end

   task automatic step(input logic [11:0] s, input logic [7:0] rd, input logic [7:0] acv);
      @(negedge CLK);
      RESET          = s[0];
      bus.LOAD_IRU   = s[1];
      bus.LOAD_IRL   = s[2];
      bus.LOAD_PC    = s[3];
      bus.INCR_PC    = s[4];
      bus.FETCH      = s[5];
      bus.LOAD_SP    = s[6];
      bus.DECR_SP    = s[7];
      bus.INCR_SP    = s[8];
      bus.FETCH_SP   = s[9];
      bus.FETCH_DATA = s[10];
      bus.STORE_MEM  = s[11];
      bus.mem_rdata  = rd;
      bus.ac         = acv;
      now_c          = mcyc;
   endtask

   // Expectation on combinational outputs in the current cycle.
   task automatic exp_now(input int sel, input logic [15:0] v, input string nm);
      exp_t e;
      e.due = now_c; e.sel = sel; e.val = v; e.nm = nm;
      sb.push_back(e);
   endtask

   // Expectation on registered outputs after the coming rising edge.
   task automatic exp_nxt(input int sel, input logic [15:0] v, input string nm);
      exp_t e;
      e.due = now_c + 1; e.sel = sel; e.val = v; e.nm = nm;
      sb.push_back(e);
   endtask

   initial begin
      RESET = 1'b1;
      {bus.LOAD_IRU, bus.LOAD_IRL, bus.LOAD_PC, bus.INCR_PC, bus.FETCH} = '0;
      {bus.LOAD_SP, bus.DECR_SP, bus.INCR_SP, bus.FETCH_SP, bus.FETCH_DATA, bus.STORE_MEM} = '0;
      bus.mem_rdata = '0;
      bus.ac        = '0;

      // Reset, then fetch two instruction bytes.
      step(B_RST, 8'h00, 8'h00);
      step(B_RST, 8'h00, 8'h00);
      exp_nxt(S_PC, 16'h0000, "rst_pc");
      exp_nxt(S_OPC, 16'h0000, "rst_opcode");
      exp_nxt(S_OPR, 16'h0000, "rst_operand");
      exp_nxt(S_SP, 16'h00FF, "rst_sp");
      exp_nxt(S_OVF, 16'h0000, "rst_ovf");
      exp_nxt(S_UNF, 16'h0000, "rst_unf");
      exp_nxt(S_CNT, 16'h0000, "rst_cnt");
      step(B_FET | B_IRU | B_IPC, 8'h10, 8'h00);
      exp_now(S_ADDR, 16'h0000, "fetch_addr_pc");
      exp_nxt(S_OPC, 16'h0010, "fetch_opcode");
      exp_nxt(S_PC, 16'h0001, "fetch_pc1");
      exp_nxt(S_CNT, 16'h0001, "fetch_cnt");
      step(B_FET | B_IRL | B_IPC, 8'h3C, 8'h00);
      exp_now(S_ADDR, 16'h0001, "fetch2_addr_pc");
      exp_nxt(S_OPR, 16'h003C, "fetch_operand");
      exp_nxt(S_PC, 16'h0002, "fetch_pc2");
      step(12'h000, 8'h00, 8'h00);
      exp_now(S_ADDR, 16'h003C, "idle_addr_operand");

      // Jump to FF (FETCH still shows the old PC), then wrap.
      step(B_IRL, 8'hFF, 8'h00);
      step(B_LPC | B_FET, 8'h00, 8'h00);
      exp_now(S_ADDR, 16'h0002, "jmp_addr_oldpc");
      exp_nxt(S_PC, 16'h00FF, "jmp_pc_ff");
      step(B_IPC, 8'h00, 8'h00);
      exp_nxt(S_PC, 16'h0000, "pc_wrap");
      step(B_IRL, 8'h20, 8'h00);
      step(B_LPC | B_IPC, 8'h00, 8'h00);
      exp_nxt(S_PC, 16'h0020, "ldpc_over_incr");

      // Call push: pc=42, decrement SP, then store return address at new SP.
      step(B_IRL, 8'h42, 8'h00);
      step(B_LPC, 8'h00, 8'h00);
      exp_nxt(S_PC, 16'h0042, "call_pc");
      step(B_DSP, 8'h00, 8'h00);
      exp_nxt(S_SP, 16'h00FE, "push_sp");
      step(B_FSP | B_FET | B_FDAT | B_STM, 8'h00, 8'h5A);
      exp_now(S_ADDR, 16'h00FE, "push_addr");
      exp_now(S_WD, 16'h0042, "push_wdata");
      exp_now(S_WE, 16'h0001, "push_we");
      step(B_STM, 8'h00, 8'h5A);
      exp_now(S_WD, 16'h005A, "store_wdata_ac");
      exp_now(S_ADDR, 16'h0042, "store_addr_operand");
      step(12'h000, 8'h00, 8'h5A);
      exp_now(S_WE, 16'h0000, "idle_we");

      // Overflow at the limit, cleared by LOAD_SP.
      step(B_IRL, 8'hE0, 8'h00);
      step(B_LSP, 8'h00, 8'h00);
      exp_nxt(S_SP, 16'h00E0, "ldsp_e0");
      step(B_DSP, 8'h00, 8'h00);
      exp_nxt(S_SP, 16'h00E0, "ovf_sp_hold");
      exp_nxt(S_OVF, 16'h0001, "ovf_set");
      step(12'h000, 8'h00, 8'h00);
      exp_nxt(S_OVF, 16'h0001, "ovf_sticky");
      step(B_IRL, 8'hF0, 8'h00);
      step(B_LSP, 8'h00, 8'h00);
      exp_nxt(S_SP, 16'h00F0, "ldsp_f0");
      exp_nxt(S_OVF, 16'h0000, "ovf_clear");

      // Underflow at empty, then simultaneous push/pop.
      step(B_IRL, 8'hFF, 8'h00);
      step(B_LSP, 8'h00, 8'h00);
      exp_nxt(S_SP, 16'h00FF, "ldsp_ff");
      step(B_ISP, 8'h00, 8'h00);
      exp_nxt(S_SP, 16'h00FF, "unf_sp_hold");
      exp_nxt(S_UNF, 16'h0001, "unf_set");
      step(B_IRL, 8'hF0, 8'h00);
      exp_nxt(S_UNF, 16'h0001, "unf_sticky");
      step(B_LSP, 8'h00, 8'h00);
      exp_nxt(S_UNF, 16'h0000, "unf_clear");
      step(B_DSP | B_ISP, 8'h00, 8'h00);
      exp_nxt(S_SP, 16'h00EF, "decr_over_incr");
      step(B_ISP, 8'h00, 8'h00);
      exp_nxt(S_SP, 16'h00F0, "pop_sp");

      // Mid-instruction reset overrides strobes.
      step(B_IRU, 8'h33, 8'h00);
      exp_nxt(S_CNT, 16'h0002, "cnt_two");
      step(B_RST | B_LPC | B_DSP | B_IRU, 8'h77, 8'h00);
      exp_nxt(S_PC, 16'h0000, "mrst_pc");
      exp_nxt(S_OPC, 16'h0000, "mrst_opcode");
      exp_nxt(S_OPR, 16'h0000, "mrst_operand");
      exp_nxt(S_SP, 16'h00FF, "mrst_sp");
      exp_nxt(S_CNT, 16'h0000, "mrst_cnt");
      step(12'h000, 8'h00, 8'h00);

      repeat (3) @(negedge CLK);
      #4;
      while (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL %s: never checked (due %0d)", sb[0].nm, sb[0].due);
         void'(sb.pop_front());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
